// File: rtl/outr_serial_tx_if.sv
// Bus/line bundle for the OUTR serial transmitter.
// master = CPU bus side (drives load/data), slave = transmitter.
interface outr_serial_tx_if #(
    parameter int WIDTH = 8
);
    logic             load_outr;
    logic [WIDTH-1:0] DATA_outr;
    logic [WIDTH-1:0] op_of_outr;
    logic             fgo;
    logic             tx_serial;
    logic             tx_busy;
    logic             tx_done;

    modport master (
        output load_outr,
        output DATA_outr,
        input  op_of_outr,
        input  fgo,
        input  tx_serial,
        input  tx_busy,
        input  tx_done
    );

    modport slave (
        input  load_outr,
        input  DATA_outr,
        output op_of_outr,
        output fgo,
        output tx_serial,
        output tx_busy,
        output tx_done
    );
endinterface

// File: rtl/outr_serial_tx.sv
// OUTR register + FGO flag; serialises each loaded character as
// start bit, WIDTH data bits LSB first, one stop bit.
// Ports: clk, reset_outr_n (async, active low), bus (slave):
//   load_outr/DATA_outr in; op_of_outr, fgo, tx_serial,
//   tx_busy, tx_done out.
module outr_serial_tx #(
    parameter int WIDTH        = 8,
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic reset_outr_n,
    outr_serial_tx_if.slave bus
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_e;

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [BW-1:0]    bit_idx_q, bit_idx_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [WIDTH-1:0] outr_q, outr_d;
    logic             fgo_q, fgo_d;
    logic             tx_q, tx_d;
    logic             done_q, done_d;

    logic             cnt_end;
    logic [WIDTH-1:0] shift_nxt;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        outr_d    = outr_q;
        fgo_d     = fgo_q;
        tx_d      = tx_q;
        done_d    = 1'b0;
        cnt_end   = (cnt_q == CNT_LAST);
        shift_nxt = shift_q >> 1;

        unique case (state_q)
            IDLE: begin
                tx_d  = 1'b1;
                fgo_d = 1'b1;
                if (bus.load_outr) begin
                    outr_d  = bus.DATA_outr;
                    shift_d = bus.DATA_outr;
                    fgo_d   = 1'b0;
                    tx_d    = 1'b0;
                    cnt_d   = '0;
                    state_d = START;
                end
            end
            START: begin
                if (cnt_end) begin
                    cnt_d     = '0;
                    bit_idx_d = '0;
                    tx_d      = shift_q[0];
                    state_d   = DATA;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DATA: begin
                if (cnt_end) begin
                    cnt_d = '0;
                    if (bit_idx_q == BIT_LAST) begin
                        tx_d    = 1'b1;
                        state_d = STOP;
                    end else begin
                        // next bit is already on the line at the shift
                        shift_d   = shift_nxt;
                        tx_d      = shift_nxt[0];
                        bit_idx_d = bit_idx_q + BW'(1);
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            STOP: begin
                if (cnt_end) begin
                    cnt_d   = '0;
                    fgo_d   = 1'b1;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                fgo_d   = 1'b1;
                tx_d    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_outr_n) begin
        if (!reset_outr_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            outr_q    <= '0;
            fgo_q     <= 1'b1;
            tx_q      <= 1'b1;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            outr_q    <= outr_d;
            fgo_q     <= fgo_d;
            tx_q      <= tx_d;
            done_q    <= done_d;
        end
    end

    assign bus.op_of_outr = outr_q;
    assign bus.fgo        = fgo_q;
    assign bus.tx_serial  = tx_q;
    assign bus.tx_busy    = ~fgo_q;
    assign bus.tx_done    = done_q;

endmodule

// File: tb/tb_outr_serial_tx.sv
// Bench for outr_serial_tx: two instances (8/4 and 7/2) checked
// every cycle against a frame-timing reference model.
module tb_outr_serial_tx;

    localparam int WA = 8;
    localparam int NA = 4;
    localparam int WB = 7;
    localparam int NB = 2;

    logic clk = 1'b0;
    logic rst_a;
    logic rst_b;

    always #5 clk = ~clk;

    outr_serial_tx_if #(.WIDTH(WA)) bus_a ();
    outr_serial_tx_if #(.WIDTH(WB)) bus_b ();

    outr_serial_tx #(.WIDTH(WA), .CLKS_PER_BIT(NA)) u_a (
        .clk          (clk),
        .reset_outr_n (rst_a),
        .bus          (bus_a)
    );

    outr_serial_tx #(.WIDTH(WB), .CLKS_PER_BIT(NB)) u_b (
        .clk          (clk),
        .reset_outr_n (rst_b),
        .bus          (bus_b)
    );

    int nchk = 0;
    int nerr = 0;
    int cyc  = 0;

    // reference model: a frame is just its start edge and its data
    int          wm[2] = '{WA, WB};
    int          nm[2] = '{NA, NB};
    bit          have[2];
    int          start[2];
    logic [31:0] frm[2];
    logic [31:0] outr_m[2];

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     tag, got, exp, cyc);
        end
    endtask

    function automatic logic fbit(logic [31:0] d, int el, int n, int w);
        int b;
        b = el / n;
        if (b == 0) return 1'b0;
        if (b <= w) return d[b-1];
        return 1'b1;
    endfunction

    task automatic model_edge(int i, logic rn, logic ld, logic [31:0] d);
        int f;
        f = (wm[i] + 2) * nm[i];
        if (!rn) begin
            have[i]   = 1'b0;
            outr_m[i] = '0;
        end else if (ld && (!have[i] || (cyc - start[i]) > f)) begin
            have[i]   = 1'b1;
            start[i]  = cyc;
            frm[i]    = d;
            outr_m[i] = d;
        end
    endtask

    task automatic cmp(int i, logic [31:0] op, logic fg, logic tx,
                       logic bz, logic dn);
        int   el;
        int   f;
        logic eb;
        logic ed;
        logic et;
        f  = (wm[i] + 2) * nm[i];
        el = cyc - start[i];
        eb = have[i] && (el < f);
        ed = have[i] && (el == f);
        et = eb ? fbit(frm[i], el, nm[i], wm[i]) : 1'b1;
        check($sformatf("op%0d", i), op, outr_m[i]);
        check($sformatf("fgo%0d", i), 32'(fg), 32'(!eb));
        check($sformatf("tx%0d", i), 32'(tx), 32'(et));
        check($sformatf("busy%0d", i), 32'(bz), 32'(eb));
        check($sformatf("done%0d", i), 32'(dn), 32'(ed));
    endtask

    task automatic cmp_all();
        cmp(0, 32'(bus_a.op_of_outr), bus_a.fgo, bus_a.tx_serial,
            bus_a.tx_busy, bus_a.tx_done);
        cmp(1, 32'(bus_b.op_of_outr), bus_b.fgo, bus_b.tx_serial,
            bus_b.tx_busy, bus_b.tx_done);
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        model_edge(0, rst_a, bus_a.load_outr, 32'(bus_a.DATA_outr));
        model_edge(1, rst_b, bus_b.load_outr, 32'(bus_b.DATA_outr));
        #1;
        cmp_all();
    endtask

    task automatic load_a(logic [7:0] d);
        bus_a.load_outr = 1'b1;
        bus_a.DATA_outr = d;
        tick();
        bus_a.load_outr = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not end in time");
        $fatal(1, "timeout");
    end

    initial begin
        logic [9:0] seq;
        logic [7:0] bits8;
        logic [6:0] bits7;

        rst_a = 1'b0;
        rst_b = 1'b0;
        bus_a.load_outr = 1'b0;
        bus_a.DATA_outr = '0;
        bus_b.load_outr = 1'b0;
        bus_b.DATA_outr = '0;
        for (int i = 0; i < 2; i++) begin
            have[i] = 1'b0;
            start[i] = 0;
            frm[i] = '0;
            outr_m[i] = '0;
        end

        // reset held 3 cycles, then 20 idle cycles
        repeat (3) tick();
        rst_a = 1'b1;
        rst_b = 1'b1;
        repeat (20) tick();
        check("rst_op", 32'(bus_a.op_of_outr), 32'h0);
        check("rst_tx", 32'(bus_a.tx_serial), 32'h1);

        // single frame 0xA5, mid-bit samples
        load_a(8'hA5);
        check("t2_op", 32'(bus_a.op_of_outr), 32'hA5);
        check("t2_fgo0", 32'(bus_a.fgo), 32'h0);
        seq = '0;
        for (int i = 1; i <= 40; i++) begin
            if (i % 4 == 2) seq[i/4] = bus_a.tx_serial;
            tick();
        end
        check("t2_bits", 32'(seq), 32'(10'b1101001010));
        check("t2_fgo1", 32'(bus_a.fgo), 32'h1);
        check("t2_done", 32'(bus_a.tx_done), 32'h1);
        tick();
        check("t2_done1", 32'(bus_a.tx_done), 32'h0);
        repeat (3) tick();

        // load while busy is ignored
        load_a(8'h3C);
        repeat (9) tick();
        load_a(8'hFF);
        check("t3_op", 32'(bus_a.op_of_outr), 32'h3C);
        repeat (29) tick();
        check("t3_fgo39", 32'(bus_a.fgo), 32'h0);
        tick();
        check("t3_fgo40", 32'(bus_a.fgo), 32'h1);
        repeat (2) tick();

        // back-to-back with load held high
        load_a(8'h01);
        bus_a.load_outr = 1'b1;
        bus_a.DATA_outr = 8'h80;
        repeat (39) tick();
        tick();
        check("t4_fgo40", 32'(bus_a.fgo), 32'h1);
        check("t4_tx40", 32'(bus_a.tx_serial), 32'h1);
        check("t4_op40", 32'(bus_a.op_of_outr), 32'h01);
        tick();
        bus_a.load_outr = 1'b0;
        check("t4_fgo41", 32'(bus_a.fgo), 32'h0);
        check("t4_tx41", 32'(bus_a.tx_serial), 32'h0);
        check("t4_op41", 32'(bus_a.op_of_outr), 32'h80);
        bits8 = '0;
        for (int j = 1; j <= 40; j++) begin
            tick();
            if (j % 4 == 2 && j / 4 >= 1 && j / 4 <= 8)
                bits8[j/4-1] = bus_a.tx_serial;
        end
        check("t4_bits", 32'(bits8), 32'h80);
        repeat (2) tick();

        // async reset mid-frame
        load_a(8'h55);
        repeat (13) tick();
        #2;
        rst_a = 1'b0;
        model_edge(0, 1'b0, 1'b0, 32'h0);
        #1;
        check("t5_tx", 32'(bus_a.tx_serial), 32'h1);
        check("t5_fgo", 32'(bus_a.fgo), 32'h1);
        check("t5_busy", 32'(bus_a.tx_busy), 32'h0);
        cmp_all();
        repeat (2) tick();
        rst_a = 1'b1;
        tick();
        load_a(8'h0F);
        bits8 = '0;
        for (int j = 1; j <= 40; j++) begin
            if (j % 4 == 2 && j / 4 >= 1 && j / 4 <= 8)
                bits8[j/4-1] = bus_a.tx_serial;
            tick();
        end
        check("t5_bits", 32'(bits8), 32'h0F);
        check("t5_fgo40", 32'(bus_a.fgo), 32'h1);

        // WIDTH=7, CLKS_PER_BIT=2 instance
        bus_b.load_outr = 1'b1;
        bus_b.DATA_outr = 7'h7F;
        tick();
        bus_b.load_outr = 1'b0;
        bits7 = '0;
        for (int j = 1; j <= 17; j++) begin
            if (j % 2 == 1 && j / 2 >= 1 && j / 2 <= 7)
                bits7[j/2-1] = bus_b.tx_serial;
            tick();
        end
        check("t6_bits", 32'(bits7), 32'h7F);
        check("t6_stop", 32'(bus_b.tx_serial), 32'h1);
        check("t6_fgo17", 32'(bus_b.fgo), 32'h0);
        tick();
        check("t6_fgo18", 32'(bus_b.fgo), 32'h1);
        check("t6_done", 32'(bus_b.tx_done), 32'h1);

        // random traffic with occasional mid-cycle resets
        for (int k = 0; k < 2000; k++) begin
            bus_a.load_outr = ($urandom_range(0, 5) == 0);
            bus_a.DATA_outr = 8'($urandom);
            bus_b.load_outr = ($urandom_range(0, 3) == 0);
            bus_b.DATA_outr = 7'($urandom);
            tick();
            if (!rst_a) begin
                rst_a = 1'b1;
            end else if ($urandom_range(0, 299) == 0) begin
                #2;
                rst_a = 1'b0;
                model_edge(0, 1'b0, 1'b0, 32'h0);
                #1;
                cmp_all();
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule
